uc_dispatch: RTL and testbench
==============================

UC_DISPATCH -- requirements
Module: uc_dispatch

Interface
REQ-001 SHALL have parameter UC_LENGTH, default 16, number of variables per unit-clause table; W = $clog2(UC_LENGTH)+1 is the literal width.
REQ-002 SHALL have parameter CNT_W, default 8, width of the statistics counters.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ucq_empty  input  1  unit-clause queue empty flag.
REQ-007 ucq2eng  input  W  queue head literal, valid whenever ucq_empty=0; bit W-1 is polarity (1 = negative), bits W-2:0 are the variable index.
REQ-008 ucq_pop  output  1  dequeue strobe; the queue advances on the rising edge where ucq_pop=1.
REQ-009 eng_valid  output  1  literal offered to the engine.
REQ-010 eng_lit  output  W  offered literal.
REQ-011 eng_ready  input  1  engine accepts the literal when eng_valid=1 and eng_ready=1.
REQ-012 flush  input  1  synchronous clear of all dispatch state (new decision level).
REQ-013 conflict  output  1  sticky conflict flag.
REQ-014 conflict_var  output  W-1  variable index that caused the conflict.
REQ-015 dispatch_cnt  output  CNT_W  count of literals accepted by the engine, saturating.
REQ-016 drop_cnt  output  CNT_W  count of duplicate literals dropped, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, CHECK, SEND and CONFL.
REQ-018 In IDLE, ucq_pop SHALL be 1 combinationally iff ucq_empty=0 and flush=0; ucq_pop SHALL be 0 in all other states.
REQ-019 On the edge where ucq_pop=1, the block SHALL register ucq2eng into lit_r and go IDLE->CHECK.
REQ-020 SHALL keep a seen[UC_LENGTH] bitmap and a pol[UC_LENGTH] bitmap indexed by variable.
REQ-021 In CHECK with seen[var]=0, the block SHALL set seen[var]=1 and pol[var]=polarity, then go to SEND.
REQ-022 In CHECK with seen[var]=1 and pol[var]==polarity, the literal is a duplicate: the block SHALL drop it, increment drop_cnt and go to IDLE.
REQ-023 In CHECK with seen[var]=1 and pol[var]!=polarity, the block SHALL set conflict=1 and conflict_var=var, then go to CONFL.
REQ-024 In SEND, eng_valid=1 and eng_lit=lit_r SHALL be held stable until the handshake; on eng_ready=1 the block SHALL increment dispatch_cnt and go to IDLE.
REQ-025 eng_valid SHALL be 0 in every state except SEND; eng_lit SHALL hold its last value when eng_valid=0.
REQ-026 CONFL SHALL be absorbing: no pop, no dispatch and queue contents untouched until flush or reset.
REQ-027 Minimum spacing SHALL be 3 cycles per literal (pop, check, send with immediate ready); eng_ready may stay high without restriction.
REQ-028 flush=1 SHALL win over every other event in the same cycle: next state IDLE, bitmaps cleared, conflict and conflict_var cleared, both counters cleared, eng_valid 0 next cycle; a literal in CHECK or SEND is discarded, not re-queued.
REQ-029 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-030 An index with var >= UC_LENGTH SHALL be treated as a duplicate and dropped; the bitmap SHALL NOT be written.
REQ-031 ucq_empty rising while in CHECK or SEND SHALL NOT affect the literal in flight.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state IDLE, clear seen, pol, lit_r, conflict, conflict_var, dispatch_cnt and drop_cnt, and drive ucq_pop=0, eng_valid=0 and eng_lit=0.
REQ-033 Reset asserted mid-SEND SHALL drop eng_valid immediately without waiting for a clock edge; after release, the first pop SHALL occur no earlier than the first edge with rst_n=1.

Verification (UC_LENGTH=16, W=5)
REQ-034 Queue holds 02,04,06,08,0A with eng_ready=1 -> each pops once, eng_lit shows the same sequence in order, and dispatch_cnt=5 with the queue empty.
REQ-035 Queue holds 02,02 -> one dispatch of 02; drop_cnt=1, dispatch_cnt=1.
REQ-036 Queue holds 02,12 -> 02 is dispatched; at 12, conflict=1 and conflict_var=2; afterwards ucq_pop stays 0 with the queue non-empty.
REQ-037 eng_ready=0 for 4 cycles while in SEND with 04 -> eng_valid=1 and eng_lit=04 held all 4 cycles, no pop during that time, and dispatch_cnt increments only on the ready cycle.
REQ-038 flush during CONFL, then push 12 -> conflict=0 and counters 0, then 12 is dispatched normally.
REQ-039 rst_n dropped mid-SEND -> eng_valid=0 immediately; after release all outputs read 0 and the next queue entry pops normally.

Source files
------------

// File: rtl/uc_dispatch_if.sv
// Unit-clause dispatch bus.
// Bundles the queue-side handshake (ucq_empty, ucq2eng, ucq_pop) and the
// engine-side handshake (eng_valid, eng_lit, eng_ready).
//   master : the dispatcher (pops the queue, offers literals to the engine)
//   slave  : the environment (queue + engine)
// W is the literal width: bit W-1 is polarity (1 = negative), W-2:0 the variable.
interface uc_dispatch_if #(
   parameter int unsigned W = 5
);
   logic         ucq_empty;
   logic [W-1:0] ucq2eng;
   logic         ucq_pop;
   logic         eng_valid;
   logic [W-1:0] eng_lit;
   logic         eng_ready;

   modport master (
      input  ucq_empty,
      input  ucq2eng,
      input  eng_ready,
      output ucq_pop,
      output eng_valid,
      output eng_lit
   );

   modport slave (
      output ucq_empty,
      output ucq2eng,
      output eng_ready,
      input  ucq_pop,
      input  eng_valid,
      input  eng_lit
   );
endinterface

// File: rtl/uc_dispatch.sv
// Unit-clause dispatcher.
// Pops literals from the unit-clause queue, filters duplicates, detects
// opposite-polarity conflicts and forwards new literals to the engine.
//   clk, rst_n    : clock, asynchronous active-low reset
//   flush         : synchronous clear of all dispatch state
//   bus           : queue + engine handshakes (master side)
//   conflict      : sticky conflict flag, conflict_var its variable
//   dispatch_cnt  : literals accepted by the engine (saturating)
//   drop_cnt      : duplicate literals dropped (saturating)
module uc_dispatch #(
   parameter int unsigned UC_LENGTH = 16,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   uc_dispatch_if.master                bus,
   output logic                         conflict,
   output logic [$clog2(UC_LENGTH)-1:0] conflict_var,
   output logic [CNT_W-1:0]             dispatch_cnt,
   output logic [CNT_W-1:0]             drop_cnt
);

   localparam int unsigned W  = $clog2(UC_LENGTH) + 1;
   localparam int unsigned VW = W - 1;

   typedef enum logic [1:0] {StIdle, StCheck, StSend, StConfl} state_t;

   state_t             state, state_nxt;
   logic [W-1:0]       lit_r;
   logic [W-1:0]       eng_lit_r;
   logic [UC_LENGTH-1:0] seen;
   logic [UC_LENGTH-1:0] pol;

   logic [VW-1:0] var_idx;
   logic          polarity;
   logic          in_range;
   logic          pop, mark, drop, confl, disp;

   assign var_idx  = lit_r[VW-1:0];
   assign polarity = lit_r[W-1];
   assign in_range = (32'(var_idx) < UC_LENGTH);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      mark      = 1'b0;
      drop      = 1'b0;
      confl     = 1'b0;
      disp      = 1'b0;
      case (state)
         StIdle: begin
            // rst_n gate keeps pop low while reset holds the FSM in idle
            if (!bus.ucq_empty && !flush && rst_n) begin
               pop       = 1'b1;
               state_nxt = StCheck;
            end
         end
         StCheck: begin
            // out-of-range variables behave as duplicates, bitmap untouched
            if (!in_range) begin
               drop      = 1'b1;
               state_nxt = StIdle;
            end else if (!seen[var_idx]) begin
               mark      = 1'b1;
               state_nxt = StSend;
            end else if (pol[var_idx] == polarity) begin
               drop      = 1'b1;
               state_nxt = StIdle;
            end else begin
               confl     = 1'b1;
               state_nxt = StConfl;
            end
         end
         StSend: begin
            if (bus.eng_ready) begin
               disp      = 1'b1;
               state_nxt = StIdle;
            end
         end
         StConfl: state_nxt = StConfl;
         default: state_nxt = StIdle;
      endcase
      if (flush) begin
         state_nxt = StIdle;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= StIdle;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lit_r        <= '0;
         eng_lit_r    <= '0;
         seen         <= '0;
         pol          <= '0;
         conflict     <= 1'b0;
         conflict_var <= '0;
         dispatch_cnt <= '0;
         drop_cnt     <= '0;
      end else if (flush) begin
         seen         <= '0;
         pol          <= '0;
         conflict     <= 1'b0;
         conflict_var <= '0;
         dispatch_cnt <= '0;
         drop_cnt     <= '0;
      end else begin
         if (pop) begin
            lit_r <= bus.ucq2eng;
         end
         if (mark) begin
            seen[var_idx] <= 1'b1;
            pol[var_idx]  <= polarity;
            // eng_lit only changes when a new literal is offered
            eng_lit_r     <= lit_r;
         end
         if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
         if (confl) begin
            conflict     <= 1'b1;
            conflict_var <= var_idx;
         end
         if (disp && (dispatch_cnt != '1)) begin
            dispatch_cnt <= dispatch_cnt + 1'b1;
         end
      end
   end

   assign bus.ucq_pop   = pop;
   assign bus.eng_valid = (state == StSend);
   assign bus.eng_lit   = eng_lit_r;

endmodule

// File: tb/tb_uc_dispatch.sv
// Directed self-checking bench for uc_dispatch (UC_LENGTH=16, W=5, CNT_W=8).
// A small queue model feeds the dispatcher; accepted literals are logged.
module tb_uc_dispatch;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       ready;
   logic       conflict;
   logic [3:0] conflict_var;
   logic [7:0] dispatch_cnt;
   logic [7:0] drop_cnt;

   int checks   = 0;
   int failures = 0;

   logic [4:0] q [0:1023];
   int head    = 0;
   int tail    = 0;
   int pop_cnt = 0;

   logic [4:0] log_q [0:63];
   int n_log = 0;

   uc_dispatch_if #(.W(5)) bus ();

   uc_dispatch #(
      .UC_LENGTH (16),
      .CNT_W     (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .bus          (bus),
      .conflict     (conflict),
      .conflict_var (conflict_var),
      .dispatch_cnt (dispatch_cnt),
      .drop_cnt     (drop_cnt)
   );

   assign bus.ucq_empty = (head == tail);
   assign bus.ucq2eng   = q[head];
   assign bus.eng_ready = ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.ucq_pop === 1'b1) begin
         head    <= head + 1;
         pop_cnt <= pop_cnt + 1;
      end
      if (bus.eng_valid === 1'b1 && ready === 1'b1) begin
         log_q[n_log] <= bus.eng_lit;
         n_log        <= n_log + 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] lit);
      q[tail] = lit;
      tail++;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      ready = 1'b1;
      #2;
      // Sequence 02..0A queued while reset is held
      push(5'h02); push(5'h04); push(5'h06); push(5'h08); push(5'h0A);
      @(negedge clk);
      @(negedge clk);
      chk("rst_pop",      32'(bus.ucq_pop),   0);
      chk("rst_valid",    32'(bus.eng_valid), 0);
      chk("rst_lit",      32'(bus.eng_lit),   0);
      chk("rst_conflict", 32'(conflict),      0);
      chk("rst_cvar",     32'(conflict_var),  0);
      chk("rst_dcnt",     32'(dispatch_cnt),  0);
      chk("rst_drcnt",    32'(drop_cnt),      0);
      rst_n = 1'b1;

      // 3 cycles per literal with ready high: 4 accepted after 14 edges, 5 after 15
      repeat (14) tick();
      chk("seq_dcnt_14", 32'(dispatch_cnt), 4);
      tick();
      chk("seq_dcnt_15", 32'(dispatch_cnt), 5);
      chk("seq_empty",   32'(bus.ucq_empty), 1);
      chk("seq_pops",    32'(pop_cnt), 5);
      chk("seq_nlog",    32'(n_log), 5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("seq_lit%0d", i), 32'(log_q[i]), 32'(2 * (i + 1)));
      end

      // Duplicate 02,02
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl1_dcnt", 32'(dispatch_cnt), 0);
      push(5'h02); push(5'h02);
      repeat (8) tick();
      chk("dup_dcnt",  32'(dispatch_cnt), 1);
      chk("dup_drcnt", 32'(drop_cnt), 1);
      chk("dup_nlog",  32'(n_log), 6);
      chk("dup_lit",   32'(log_q[5]), 32'h02);

      // Conflict 02 then 12, with 06 left waiting
      flush = 1'b1;
      tick();
      flush = 1'b0;
      push(5'h02); push(5'h12); push(5'h06);
      repeat (8) tick();
      chk("cf_conflict", 32'(conflict), 1);
      chk("cf_cvar",     32'(conflict_var), 2);
      chk("cf_pop",      32'(bus.ucq_pop), 0);
      chk("cf_empty",    32'(bus.ucq_empty), 0);
      chk("cf_dcnt",     32'(dispatch_cnt), 1);
      chk("cf_valid",    32'(bus.eng_valid), 0);
      repeat (3) tick();
      chk("cf_head",     32'(head), 32'(tail - 1));
      chk("cf_nlog",     32'(n_log), 7);

      // Flush out of conflict, then 06 and 12 dispatch normally
      flush = 1'b1;
      #1;
      chk("fl_pop", 32'(bus.ucq_pop), 0);
      @(negedge clk);
      flush = 1'b0;
      chk("fl_conflict", 32'(conflict), 0);
      chk("fl_cvar",     32'(conflict_var), 0);
      chk("fl_dcnt",     32'(dispatch_cnt), 0);
      chk("fl_drcnt",    32'(drop_cnt), 0);
      push(5'h12);
      repeat (8) tick();
      chk("rc_dcnt",     32'(dispatch_cnt), 2);
      chk("rc_nlog",     32'(n_log), 9);
      chk("rc_lit06",    32'(log_q[7]), 32'h06);
      chk("rc_lit12",    32'(log_q[8]), 32'h12);
      chk("rc_conflict", 32'(conflict), 0);

      // Backpressure: 04 held for 4 cycles with 08 waiting
      ready = 1'b0;
      push(5'h04); push(5'h08);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("bp_valid%0d", i), 32'(bus.eng_valid), 1);
         chk($sformatf("bp_lit%0d", i),   32'(bus.eng_lit), 32'h04);
         chk($sformatf("bp_pop%0d", i),   32'(bus.ucq_pop), 0);
         chk($sformatf("bp_dcnt%0d", i),  32'(dispatch_cnt), 2);
         if (i < 3) tick();
      end
      ready = 1'b1;
      tick();
      chk("bp_dcnt_acc", 32'(dispatch_cnt), 3);
      chk("bp_valid_lo", 32'(bus.eng_valid), 0);
      chk("bp_lit_hold", 32'(bus.eng_lit), 32'h04);
      chk("bp_pop_next", 32'(bus.ucq_pop), 1);
      repeat (3) tick();
      chk("bp_dcnt_08",  32'(dispatch_cnt), 4);
      chk("bp_lit_08",   32'(log_q[10]), 32'h08);

      // Reset mid-SEND drops eng_valid without a clock edge
      ready = 1'b0;
      push(5'h0A);
      tick();
      tick();
      chk("rs_valid_pre", 32'(bus.eng_valid), 1);
      chk("rs_lit_pre",   32'(bus.eng_lit), 32'h0A);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rs_valid",    32'(bus.eng_valid), 0);
      chk("rs_pop",      32'(bus.ucq_pop), 0);
      chk("rs_lit",      32'(bus.eng_lit), 0);
      chk("rs_dcnt",     32'(dispatch_cnt), 0);
      chk("rs_conflict", 32'(conflict), 0);
      push(5'h0C);
      #1;
      chk("rs_pop_q",    32'(bus.ucq_pop), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ready = 1'b1;
      repeat (3) tick();
      chk("rs_dcnt_post", 32'(dispatch_cnt), 1);
      chk("rs_nlog",      32'(n_log), 12);
      chk("rs_lit_post",  32'(log_q[11]), 32'h0C);

      // Flush blocks a pop in idle; then saturate drop_cnt with 260 duplicates
      flush = 1'b1;
      push(5'h02);
      #1;
      chk("sat_flush_pop", 32'(bus.ucq_pop), 0);
      @(negedge clk);
      flush = 1'b0;
      for (int i = 0; i < 260; i++) push(5'h02);
      repeat (540) tick();
      chk("sat_drcnt", 32'(drop_cnt), 255);
      chk("sat_dcnt",  32'(dispatch_cnt), 1);
      chk("sat_empty", 32'(bus.ucq_empty), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
